// File: rtl/usb_cdc_stream_bridge.sv
// ---------------------------------------------------------------------------
// usb_cdc_stream_bridge
//
// Glue between the usb_cdc byte streams and the application word interface.
// Host->device bytes are buffered in an RX byte FIFO and packed little-endian
// into WORD_BYTES-wide words; application words are unpacked into a TX byte
// FIFO that feeds usb_cdc. A partially packed RX word is flushed with a short
// keep mask after RX_TIMEOUT idle cycles. In loopback mode RX bytes are routed
// straight into the TX FIFO. Whenever the device is unconfigured, all buffers
// and in-flight words are discarded.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   configured_i          usb_cdc configured flag; low clears and blocks
//   cfg_loopback_i        requested loopback mode
//   usb_out_*             host->device byte stream (bridge is the sink)
//   usb_in_*              device->host byte stream (bridge is the source)
//   app_rx_*              packed RX words to the application (data/keep/valid/ready)
//   app_tx_*              TX words from the application (data/keep/valid/ready)
//   rx_level_o/tx_level_o byte FIFO occupancies
// ---------------------------------------------------------------------------

// Byte FIFO with show-ahead output. Callers only push when not full (or while
// popping) and only pop when not empty; the internal gating makes both safe.
//   clr    synchronous clear of pointers and count
//   push/din, pop/dout, empty/full, level
module usb_cdc_stream_bridge_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when a pop frees a slot this edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign level   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module usb_cdc_stream_bridge #(
  parameter int WORD_BYTES = 1,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int RX_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          configured_i,
  input  logic                          cfg_loopback_i,
  input  logic [7:0]                    usb_out_data_i,
  input  logic                          usb_out_valid_i,
  output logic                          usb_out_ready_o,
  output logic [7:0]                    usb_in_data_o,
  output logic                          usb_in_valid_o,
  input  logic                          usb_in_ready_i,
  output logic [8*WORD_BYTES-1:0]       app_rx_data_o,
  output logic [WORD_BYTES-1:0]         app_rx_keep_o,
  output logic                          app_rx_valid_o,
  input  logic                          app_rx_ready_i,
  input  logic [8*WORD_BYTES-1:0]       app_tx_data_i,
  input  logic [WORD_BYTES-1:0]         app_tx_keep_i,
  input  logic                          app_tx_valid_i,
  output logic                          app_tx_ready_o,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level_o,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level_o
);
  localparam int CW      = $clog2(WORD_BYTES + 1);
  localparam int TW      = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {PK_EMPTY, PK_FILLING, PK_FULL} pk_state_t;
  typedef enum logic       {UP_IDLE, UP_SEND} up_state_t;

  // clear: reset or unconfigured this edge. clear_d_reg keeps every handshake
  // blocked for one extra cycle after a clear so nothing moves mid-recovery.
  logic clear;
  logic clear_d_reg;
  logic run;
  logic loop_reg;

  assign clear = ~rst_n | ~configured_i;
  assign run   = rst_n & configured_i & ~clear_d_reg;

  always_ff @(posedge clk) begin
    clear_d_reg <= clear;
  end

  // FIFO plumbing
  logic       rx_push, rx_fifo_pop, rx_empty, rx_full;
  logic [7:0] rx_dout;
  logic       tx_push, tx_fifo_pop, tx_empty, tx_full;
  logic [7:0] tx_din, tx_dout;

  usb_cdc_stream_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .clr   (clear),
    .push  (rx_push),
    .din   (usb_out_data_i),
    .pop   (rx_fifo_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .level (rx_level_o)
  );

  usb_cdc_stream_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .clr   (clear),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_fifo_pop),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full),
    .level (tx_level_o)
  );

  // Packer / unpacker state
  pk_state_t               pk_state_reg;
  logic [CW-1:0]           pk_cnt_reg;
  logic [8*WORD_BYTES-1:0] pk_data_reg;
  logic [WORD_BYTES-1:0]   pk_keep_reg;
  logic [TW-1:0]           to_cnt_reg;
  logic [WORD_BYTES-1:0]   keep_fill;
  up_state_t               up_state_reg;
  logic [8*WORD_BYTES-1:0] up_data_reg;
  logic [WORD_BYTES-1:0]   up_keep_reg;
  logic [WORD_BYTES-1:0]   up_keep_shift;

  logic rx_pop;
  logic loop_move;
  logic rx_accept;
  logic tx_accept;
  logic up_push;
  logic timeout_hit;

  // Handshake qualifiers; none of the ready terms look at their own valid.
  assign usb_out_ready_o = run & ~rx_full;
  assign rx_push         = usb_out_ready_o & usb_out_valid_i;
  assign rx_pop          = run & ~loop_reg & ~rx_empty & (pk_state_reg != PK_FULL);
  assign loop_move       = run & loop_reg & ~rx_empty & ~tx_full;
  assign rx_fifo_pop     = rx_pop | loop_move;

  assign app_rx_valid_o  = run & ~loop_reg & (pk_state_reg == PK_FULL);
  assign app_rx_data_o   = pk_data_reg;
  assign app_rx_keep_o   = pk_keep_reg;
  assign rx_accept       = app_rx_valid_o & app_rx_ready_i;

  assign app_tx_ready_o  = run & ~loop_reg & (up_state_reg == UP_IDLE);
  assign tx_accept       = app_tx_ready_o & app_tx_valid_i;
  assign up_push         = run & (up_state_reg == UP_SEND) & ~tx_full;
  assign up_keep_shift   = up_keep_reg >> 1;

  // Loopback and the unpacker never push together: loopback is only entered
  // with the unpacker idle, and the unpacker cannot accept while looping.
  assign tx_push         = loop_move | up_push;
  assign tx_din          = loop_reg ? rx_dout : up_data_reg[7:0];

  assign usb_in_valid_o  = run & ~tx_empty;
  assign usb_in_data_o   = usb_in_valid_o ? tx_dout : 8'h00;
  assign tx_fifo_pop     = usb_in_valid_o & usb_in_ready_i;

  // Flush mask for a timed-out partial word: one bit per byte already held.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_keep_fill
      assign keep_fill[gi] = (pk_cnt_reg > CW'(gi));
    end
  endgenerate

  assign timeout_hit = (RX_TIMEOUT != 0) && (pk_state_reg == PK_FILLING) &&
                       rx_empty && (to_cnt_reg == TW'(TO_LAST));

  // RX packer FSM with its idle counter and byte lanes.
  always_ff @(posedge clk) begin
    if (clear) begin
      pk_state_reg <= PK_EMPTY;
      pk_cnt_reg   <= '0;
      pk_data_reg  <= '0;
      pk_keep_reg  <= '0;
      to_cnt_reg   <= '0;
    end else begin
      case (pk_state_reg)
        PK_EMPTY, PK_FILLING: begin
          if (rx_pop) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (pk_cnt_reg == CW'(k)) pk_data_reg[8*k +: 8] <= rx_dout;
            end
            pk_cnt_reg <= pk_cnt_reg + 1'b1;
            to_cnt_reg <= '0;
            if (pk_cnt_reg == CW'(WORD_BYTES - 1)) begin
              pk_state_reg <= PK_FULL;
              pk_keep_reg  <= '1;
            end else begin
              pk_state_reg <= PK_FILLING;
            end
          end else if (pk_state_reg == PK_FILLING && rx_empty) begin
            if (timeout_hit) begin
              // Unwritten upper lanes are still zero from the last clear.
              pk_state_reg <= PK_FULL;
              pk_keep_reg  <= keep_fill;
              to_cnt_reg   <= '0;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end else begin
            to_cnt_reg <= '0;
          end
        end
        PK_FULL: begin
          // No pops happen in FULL, so refill starts the cycle after accept.
          if (rx_accept) begin
            pk_state_reg <= PK_EMPTY;
            pk_cnt_reg   <= '0;
            pk_data_reg  <= '0;
            pk_keep_reg  <= '0;
          end
        end
        default: pk_state_reg <= PK_EMPTY;
      endcase
    end
  end

  // TX unpacker FSM: shifts the latched word down one lane per push; the
  // shifted keep mask reaching zero marks the last valid lane.
  always_ff @(posedge clk) begin
    if (clear) begin
      up_state_reg <= UP_IDLE;
      up_data_reg  <= '0;
      up_keep_reg  <= '0;
    end else begin
      case (up_state_reg)
        UP_IDLE: begin
          if (tx_accept && (app_tx_keep_i != '0)) begin
            up_data_reg  <= app_tx_data_i;
            up_keep_reg  <= app_tx_keep_i;
            up_state_reg <= UP_SEND;
          end
        end
        UP_SEND: begin
          if (up_push) begin
            up_data_reg <= up_data_reg >> 8;
            up_keep_reg <= up_keep_shift;
            if (up_keep_shift == '0) up_state_reg <= UP_IDLE;
          end
        end
        default: up_state_reg <= UP_IDLE;
      endcase
    end
  end

  // Loopback mode only changes while both datapaths are quiescent and will
  // stay so across this edge, so no word is ever split between the modes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loop_reg <= 1'b0;
    end else if ((pk_state_reg == PK_EMPTY) && (up_state_reg == UP_IDLE) &&
                 !rx_pop && !tx_accept) begin
      loop_reg <= cfg_loopback_i;
    end
  end
endmodule

// File: tb/tb_usb_cdc_stream_bridge.sv
// Scoreboard bench for usb_cdc_stream_bridge (WORD_BYTES=4, RX_DEPTH=4,
// TX_DEPTH=8, RX_TIMEOUT=8). Stimulus pushes expected words/bytes into queues;
// two monitors pop and compare on every output handshake.
module tb_usb_cdc_stream_bridge;
  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        configured_i;
  logic        cfg_loopback_i;
  logic [7:0]  usb_out_data_i;
  logic        usb_out_valid_i;
  logic        usb_out_ready_o;
  logic [7:0]  usb_in_data_o;
  logic        usb_in_valid_o;
  logic        usb_in_ready_i;
  logic [31:0] app_rx_data_o;
  logic [3:0]  app_rx_keep_o;
  logic        app_rx_valid_o;
  logic        app_rx_ready_i;
  logic [31:0] app_tx_data_i;
  logic [3:0]  app_tx_keep_i;
  logic        app_tx_valid_i;
  logic        app_tx_ready_o;
  logic [2:0]  rx_level_o;
  logic [3:0]  tx_level_o;

  always #5 clk = ~clk;

  usb_cdc_stream_bridge #(
    .WORD_BYTES (WB),
    .RX_DEPTH   (4),
    .TX_DEPTH   (8),
    .RX_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .configured_i    (configured_i),
    .cfg_loopback_i  (cfg_loopback_i),
    .usb_out_data_i  (usb_out_data_i),
    .usb_out_valid_i (usb_out_valid_i),
    .usb_out_ready_o (usb_out_ready_o),
    .usb_in_data_o   (usb_in_data_o),
    .usb_in_valid_o  (usb_in_valid_o),
    .usb_in_ready_i  (usb_in_ready_i),
    .app_rx_data_o   (app_rx_data_o),
    .app_rx_keep_o   (app_rx_keep_o),
    .app_rx_valid_o  (app_rx_valid_o),
    .app_rx_ready_i  (app_rx_ready_i),
    .app_tx_data_i   (app_tx_data_i),
    .app_tx_keep_i   (app_tx_keep_i),
    .app_tx_valid_i  (app_tx_valid_i),
    .app_tx_ready_o  (app_tx_ready_o),
    .rx_level_o      (rx_level_o),
    .tx_level_o      (tx_level_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic exp_rx(input logic [31:0] d, input logic [3:0] k);
    rx_exp_t e;
    e.data = d;
    e.keep = k;
    rx_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends n bytes back-to-back, lowest byte of 'bytes' first.
  task automatic send_n(input logic [31:0] bytes, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      usb_out_data_i  = bytes[8*i +: 8];
      usb_out_valid_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!usb_out_ready_o && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL usb_out_wait: got ready=0 for 200 cycles, expected ready=1");
      end
      @(posedge clk);
      #1;
    end
    usb_out_valid_i = 1'b0;
    usb_out_data_i  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k);
    int t;
    app_tx_data_i  = d;
    app_tx_keep_i  = k;
    app_tx_valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!app_tx_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL app_tx_wait: got ready=0 for 200 cycles, expected ready=1");
    end
    @(posedge clk);
    #1;
    app_tx_valid_i = 1'b0;
    app_tx_data_i  = '0;
    app_tx_keep_i  = '0;
  endtask

  // RX word monitor
  always @(negedge clk) begin
    if (rst_n && app_rx_valid_o && app_rx_ready_i) begin
      if (rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got word %h keep %h, expected no word", app_rx_data_o, app_rx_keep_o);
      end else begin
        rx_exp_t e;
        e = rx_q.pop_front();
        $display("RX word %h keep %h (expected %h keep %h)", app_rx_data_o, app_rx_keep_o, e.data, e.keep);
        check("rx_data", app_rx_data_o, e.data);
        check("rx_keep", {28'h0, app_rx_keep_o}, {28'h0, e.keep});
      end
    end
  end

  // USB IN byte monitor
  always @(negedge clk) begin
    if (rst_n && usb_in_valid_o && usb_in_ready_i) begin
      if (tx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %h, expected no byte", usb_in_data_o);
      end else begin
        logic [7:0] b;
        b = tx_q.pop_front();
        $display("TX byte %h (expected %h)", usb_in_data_o, b);
        check("tx_byte", {24'h0, usb_in_data_o}, {24'h0, b});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    configured_i    = 1'b1;
    cfg_loopback_i  = 1'b0;
    usb_out_data_i  = 8'h00;
    usb_out_valid_i = 1'b0;
    usb_in_ready_i  = 1'b1;
    app_rx_ready_i  = 1'b1;
    app_tx_data_i   = '0;
    app_tx_keep_i   = '0;
    app_tx_valid_i  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_usb_out_ready", usb_out_ready_o, 0);
    check("rst_app_tx_ready", app_tx_ready_o, 0);
    check("rst_usb_in_valid", usb_in_valid_o, 0);
    check("rst_app_rx_valid", app_rx_valid_o, 0);
    check("rst_rx_level", rx_level_o, 0);
    check("rst_tx_level", tx_level_o, 0);
    check("rst_rx_data", app_rx_data_o, 0);
    check("rst_in_data", usb_in_data_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Full word pack, valid rises after the fifth edge (E4)
    exp_rx(32'h44332211, 4'hF);
    send_n(32'h44332211, 4);
    @(negedge clk);
    check("pack_valid_after_e3", app_rx_valid_o, 0);
    @(negedge clk);
    check("pack_valid_after_e4", app_rx_valid_o, 1);
    tick(3);

    // Timeout flush of a 2-byte partial word
    exp_rx(32'h0000A2A1, 4'h3);
    send_n(32'h0000A2A1, 2);
    repeat (9) @(negedge clk);
    check("timeout_valid_after_e9", app_rx_valid_o, 0);
    @(negedge clk);
    check("timeout_valid_after_e10", app_rx_valid_o, 1);
    tick(3);

    // TX unpack with keep=7, keep=0 discarded, then a single-byte word
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    tx_q.push_back(8'hCC);
    tx_q.push_back(8'hEE);
    send_word(32'hDDCCBBAA, 4'h7);
    send_word(32'h12345678, 4'h0);
    send_word(32'h000000EE, 4'h1);
    tick(12);
    @(negedge clk);
    check("tx_drained_level", tx_level_o, 0);
    check("tx_drained_valid", usb_in_valid_o, 0);
    tick(1);

    // Backpressure: packer full, RX FIFO full, ready low
    app_rx_ready_i = 1'b0;
    exp_rx(32'h04030201, 4'hF);
    exp_rx(32'h08070605, 4'hF);
    exp_rx(32'h0C0B0A09, 4'hF);
    send_n(32'h04030201, 4);
    send_n(32'h08070605, 4);
    tick(2);
    @(negedge clk);
    check("bp_rx_level", rx_level_o, 4);
    check("bp_usb_out_ready", usb_out_ready_o, 0);
    check("bp_rx_valid", app_rx_valid_o, 1);
    @(posedge clk);
    #1 app_rx_ready_i = 1'b1;
    send_n(32'h0C0B0A09, 4);
    tick(12);

    // Loopback
    cfg_loopback_i = 1'b1;
    tick(3);
    @(negedge clk);
    check("lb_app_tx_ready", app_tx_ready_o, 0);
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    @(posedge clk);
    #1;
    send_n(32'h0000C35A, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lb_rx_valid", app_rx_valid_o, 0);
    end
    tick(1);
    cfg_loopback_i = 1'b0;
    tick(3);
    @(negedge clk);
    check("lb_off_app_tx_ready", app_tx_ready_o, 1);
    tick(1);

    // Unconfigure mid-word with TX bytes queued
    usb_in_ready_i = 1'b0;
    send_word(32'h00332211, 4'h7);
    tick(5);
    @(negedge clk);
    check("cfg_tx_level_before", tx_level_o, 3);
    @(posedge clk);
    #1;
    send_n(32'h00008877, 2);
    tick(1);
    configured_i = 1'b0;
    @(negedge clk);
    check("cfg_low_usb_out_ready", usb_out_ready_o, 0);
    check("cfg_low_app_tx_ready", app_tx_ready_o, 0);
    check("cfg_low_usb_in_valid", usb_in_valid_o, 0);
    @(posedge clk);
    #1 configured_i = 1'b1;
    @(negedge clk);
    check("cfg_rec_usb_out_ready", usb_out_ready_o, 0);
    check("cfg_rec_app_tx_ready", app_tx_ready_o, 0);
    check("cfg_rec_rx_level", rx_level_o, 0);
    check("cfg_rec_tx_level", tx_level_o, 0);
    check("cfg_rec_rx_valid", app_rx_valid_o, 0);
    @(negedge clk);
    check("cfg_back_usb_out_ready", usb_out_ready_o, 1);
    check("cfg_back_app_tx_ready", app_tx_ready_o, 1);
    @(posedge clk);
    #1;
    app_rx_ready_i = 1'b1;
    usb_in_ready_i = 1'b1;
    tick(20);
    @(negedge clk);
    check("cfg_no_partial_word", app_rx_valid_o, 0);
    check("cfg_no_tx_bytes", usb_in_valid_o, 0);

    tick(5);
    check("rx_queue_empty", rx_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_cdc_stream_bridge.md
Name: usb_cdc_stream_bridge

Overview:
- Parametrised glue between the usb_cdc byte streams and the application pin side.
- Buffers both directions in byte FIFOs and packs/unpacks bytes into WORD_BYTES-wide words, little-endian.
- Flushes partial RX words on idle timeout.
- Provides a loopback mode, and clears itself whenever the USB device is unconfigured.
- Sits between u_usb_cdc and the top-level pin mapping, single clock domain.

Parameters:
- WORD_BYTES, 1, bytes per application word (1..4).
- RX_DEPTH, 16, RX byte FIFO depth (power of two, >=2).
- TX_DEPTH, 16, TX byte FIFO depth (power of two, >=2).
- RX_TIMEOUT, 64, idle cycles before a partial RX word is flushed; 0 disables flushing.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- configured_i  in  1  usb_cdc configured_o; low = flush and block.
- cfg_loopback_i  in  1  1 = route RX bytes straight to TX.
- usb_out_data_i  in  8  host->device byte from usb_cdc out_data_o.
- usb_out_valid_i  in  1  byte valid.
- usb_out_ready_o  out  1  bridge accepts byte.
- usb_in_data_o  out  8  device->host byte to usb_cdc in_data_i.
- usb_in_valid_o  out  1  byte valid.
- usb_in_ready_i  in  1  usb_cdc accepts byte.
- app_rx_data_o  out  8*WORD_BYTES  packed word; byte k at bits [8k+7:8k].
- app_rx_keep_o  out  WORD_BYTES  valid-byte mask, contiguous from bit 0.
- app_rx_valid_o  out  1  word valid.
- app_rx_ready_i  in  1  application accepts word.
- app_tx_data_i  in  8*WORD_BYTES  word to send.
- app_tx_keep_i  in  WORD_BYTES  byte mask, contiguous from bit 0.
- app_tx_valid_i  in  1  word valid.
- app_tx_ready_o  out  1  bridge accepts word.
- rx_level_o  out  clog2(RX_DEPTH+1)  RX FIFO occupancy.
- tx_level_o  out  clog2(TX_DEPTH+1)  TX FIFO occupancy.

Behaviour:
- Reset (rst_n low at clk edge): FIFOs empty, packer/unpacker empty, timeout counter 0, loopback register 0. All outputs 0 (ready outputs 0, levels 0, data 0).
- Handshakes: a transfer occurs on an edge where valid & ready. Valid, once raised, holds with stable data until the transfer. Ready never combinationally depends on its own valid.
- usb_out_ready_o = configured_i & RX FIFO not full. The write lands at the handshake edge.
- RX packer:
  - States EMPTY, FILLING, FULL.
  - Pops one byte per cycle from the RX FIFO while not FULL; the first byte goes into lane 0.
  - FULL after WORD_BYTES bytes: app_rx_valid_o=1, keep = all ones.
  - FULL -> EMPTY on the accept edge. The pack register is refilled no earlier than the cycle after acceptance.
  - Latency, WORD_BYTES=1, empty bridge: byte handshake at edge E0, app_rx_valid_o high after E1.
- RX timeout:
  - Counter runs while in FILLING with the RX FIFO empty, and resets on any pop.
  - At RX_TIMEOUT the packer goes to FULL with keep = (1<<n)-1 for n bytes held; upper lanes are 0.
- TX unpacker:
  - States IDLE, SEND.
  - app_tx_ready_o = configured_i & ~loopback & IDLE.
  - On accept, latches word and keep. keep==0 is accepted and discarded, staying IDLE.
  - In SEND, pushes lanes 0..n-1 one per cycle into the TX FIFO, stalling while the FIFO is full. Returns to IDLE after the last lane.
- usb_in_valid_o = TX FIFO not empty, with first-word data on usb_in_data_o. Pop on handshake.
- Loopback:
  - The loopback register samples cfg_loopback_i only when the packer is EMPTY and the unpacker is IDLE; otherwise it holds its old value.
  - While active, RX FIFO bytes move to the TX FIFO at one per cycle when the TX FIFO is not full.
  - While active: app_rx_valid_o=0, app_tx_ready_o=0, packer unused.
- FIFO boundaries:
  - Simultaneous push and pop on a full or empty FIFO are both legal; level is unchanged on full.
  - A push to an empty FIFO is visible at the output the next cycle.
  - Read and write pointers wrap modulo DEPTH.
- configured_i low (sampled each edge): same effect as reset on FIFOs, packer, unpacker, counter and levels. All ready/valid outputs are 0 during that cycle and the next. The loopback register is retained.
- Reset or configured_i low mid-word: the partial word is discarded; no keep-masked word is emitted.

Test Plan:
- WORD_BYTES=4: send bytes 0x11,0x22,0x33,0x44 back-to-back -> one word 0x44332211, keep=4'hF, app_rx_valid_o high after edge E4.
- WORD_BYTES=4, RX_TIMEOUT=8: send 0xA1,0xA2 then idle -> 8 idle cycles after the last pop, word 0x0000A2A1 with keep=4'h3.
- TX word 0xDDCCBBAA with keep=4'h7, usb_in_ready_i=1 -> bytes AA,BB,CC on usb_in, then valid low; keep=0 word -> nothing emitted.
- RX_DEPTH=4, app_rx_ready_i=0, WORD_BYTES=1: push 6 bytes -> packer holds 1 byte, FIFO holds 4, usb_out_ready_o low, rx_level_o=4. Release ready -> all 6 bytes delivered in order.
- cfg_loopback_i=1: send 0x5A, 0xC3 -> same bytes appear on usb_in_data_o in order, app_rx_valid_o stays 0.
- configured_i dropped mid-word with 2 bytes packed and tx_level_o=3 -> levels 0 within 1 cycle, no partial word out, ready outputs low for 2 cycles.
